// File: rtl/branch_hazard_ctrl_if.sv
// Decode-stage hazard/branch control bundle between the pipeline datapath and branch_hazard_ctrl.
interface branch_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic              id_branch;
    logic              id_jump;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic              mem_memread;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              cmp_mux1_sel;
    logic              cmp_mux2_sel;
    logic              stalling;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_branch, id_jump, id_rs1, id_rs2,
               ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               cmp_mux1_sel, cmp_mux2_sel, stalling, stall_count
    );

    modport slave (
        input  id_valid, id_branch, id_jump, id_rs1, id_rs2,
               ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               cmp_mux1_sel, cmp_mux2_sel, stalling, stall_count
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Decode-stage branch sequencing: comparator operand select, stall on unavailable operands,
// IF/ID flush after a taken redirect, and a saturating stall-cycle counter.
module branch_hazard_ctrl #(
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 CLK,
    input  logic                 Reset,
    branch_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] need1;
    logic [1:0] need2;
    logic [1:0] need_max;
    logic       fwd_sel1;
    logic       fwd_sel2;

    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_bubble_c;
    logic sel1_c;
    logic sel2_c;
    logic stalling_c;

    // Returns {need[1:0], sel}; EX is checked first so the younger producer wins.
    function automatic logic [2:0] op_eval(
        input logic              qual,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] e_rd,
        input logic              e_rw,
        input logic              e_mr,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_rw,
        input logic              m_mr
    );
        logic [2:0] r;
        r = 3'b001;
        if (qual && !((ZERO_REG_EN != 0) && (rs == '0))) begin
            if (e_rw && (e_rd == rs)) begin
                r = e_mr ? 3'b101 : 3'b011;
            end else if (m_rw && (m_rd == rs)) begin
                r = m_mr ? 3'b011 : 3'b000;
            end
        end
        return r;
    endfunction

    always_comb begin
        logic       qual;
        logic [2:0] r1;
        logic [2:0] r2;
        qual = bus.id_valid && bus.id_branch;
        r1 = op_eval(qual, bus.id_rs1, bus.ex_rd, bus.ex_regwrite, bus.ex_memread,
                     bus.mem_rd, bus.mem_regwrite, bus.mem_memread);
        r2 = op_eval(qual, bus.id_rs2, bus.ex_rd, bus.ex_regwrite, bus.ex_memread,
                     bus.mem_rd, bus.mem_regwrite, bus.mem_memread);
        need1    = r1[2:1];
        fwd_sel1 = r1[0];
        need2    = r2[2:1];
        fwd_sel2 = r2[0];
        need_max = (need1 > need2) ? need1 : need2;
    end

    // Outputs are gated by Reset so the RUN defaults appear immediately, whatever the inputs.
    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        sel1_c        = 1'b1;
        sel2_c        = 1'b1;
        stalling_c    = 1'b0;
        state_d       = state_q;
        if (Reset) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (need_max != 2'd0) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                        stalling_c    = 1'b1;
                        if (need_max == 2'd2) begin
                            state_d = HOLD;
                        end
                    end else begin
                        sel1_c = fwd_sel1;
                        sel2_c = fwd_sel2;
                        if (bus.id_valid && bus.id_jump) begin
                            ifid_flush_c = 1'b1;
                            state_d      = FLUSH;
                        end
                    end
                end
                HOLD: begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                    stalling_c    = 1'b1;
                    state_d       = RUN;
                end
                FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (stalling_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.ifid_write   = ifid_write_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.cmp_mux1_sel = sel1_c;
    assign bus.cmp_mux2_sel = sel2_c;
    assign bus.stalling     = stalling_c;
    assign bus.stall_count  = cnt_q;

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Pipeline sequencing controller for the decode stage, where conditional branches and jumps resolve.
- Selects the forwarded or register-file operand for each branch comparator input.
- Freezes PC and IF/ID and injects an ID/EX bubble when a branch operand is not yet available.
- Flushes IF/ID after a taken branch or jump.
- Keeps a saturating count of stall cycles for performance checks.

Parameters:
- REG_AW, 3, width of register address fields (ir[8:6], ir[11:9], ir[5:3]).
- ZERO_REG_EN, 1, when 1 register address 0 never creates a hazard.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  reset, asynchronous, active-high.
- id_valid  input  1  ID holds a real instruction, not a bubble.
- id_branch  input  1  ID instruction is a conditional branch that uses the comparator.
- id_jump  input  1  ID redirect taken (branch taken, or jump); the decode-stage jump result.
- id_rs1  input  REG_AW  comparator operand 1 address.
- id_rs2  input  REG_AW  comparator operand 2 address.
- ex_rd  input  REG_AW  EX destination register.
- ex_regwrite  input  1  EX writes a register.
- ex_memread  input  1  EX is a load.
- mem_rd  input  REG_AW  MEM destination register.
- mem_regwrite  input  1  MEM writes a register.
- mem_memread  input  1  MEM is a load.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID clear to bubble at the next edge.
- idex_bubble  output  1  ID/EX loads a bubble (all control zero).
- cmp_mux1_sel  output  1  comparatorMux1Control.
- cmp_mux2_sel  output  1  comparatorMux2Control.
- stalling  output  1  a stall is active this cycle.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Mux select encoding: 0 selects the forwarded value (mux input a, the MEM ALU result); 1 selects the register-file value (input b).
- Operand k hazard check (k=1,2): qualified by id_valid & id_branch & !(ZERO_REG_EN & rsk==0).
- EX match (ex_regwrite & ex_rd==rsk): need=2 if ex_memread, else need=1.
- Else MEM match (mem_regwrite & mem_rd==rsk): need=1 if mem_memread, else need=0 with forward (sel=0).
- Else need=0 and sel=1.
- N = max(need1, need2).
- FSM states: RUN, HOLD, FLUSH. Outputs are Mealy in RUN and Moore in HOLD and FLUSH.
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, sel=1, stalling=0.
- RUN, N>0: stall this cycle (pc_write=0, ifid_write=0, idex_bubble=1, stalling=1). id_jump is ignored because comparator data is invalid.
  - N=2 → HOLD.
  - N=1 → stay in RUN; the next cycle re-evaluates.
- RUN, N=0: sel per operand as above.
  - If id_valid & id_jump: ifid_flush=1, pc_write=1 → FLUSH.
- HOLD: unconditional stall (same stall outputs), sel=1, hazard logic not evaluated → RUN.
- FLUSH: ID holds a squashed bubble. Hazard and jump inputs are ignored, default outputs apply → RUN.
- WB-to-ID bypass is not this block's job; the register file is write-before-read.
- stall_count increments by 1 on every cycle with stalling=1 and saturates at all-ones; it never wraps.
- Reset (asynchronous, any state, including mid-HOLD): state=RUN, stall_count=0.
- Outputs are combinational from state, so while Reset is asserted they are the RUN defaults, with no stall and no flush.
- Simultaneous EX and MEM match on the same operand: EX (the younger instruction) wins.
- The two operands are evaluated independently: one may forward while the other stalls; stall wins overall.

Test Plan:
- Branch rs1=3, MEM ALU writes r3, no EX match → sel1=0, sel2=1, no stall, stall_count stays 0.
- Branch rs2=5, EX load to r5 → cycle0 stall, HOLD cycle stall with sel=1, then RUN with no hazard; stall_count=2, pc_write low exactly 2 cycles.
- Branch rs1=2, EX ALU writes r2 → 1 stall. Next cycle (r2 now in MEM, ALU) sel1=0, no stall; stall_count=1.
- Jump taken in RUN with N=0 → ifid_flush=1 that cycle. Next cycle FLUSH ignores id_branch with a matching ex_rd (no stall), then returns to RUN.
- Branch rs1=0, EX writes r0 with ZERO_REG_EN=1 → no stall, sel1=1. Force stall_count to 0xFFFE and stall 3 cycles → holds 0xFFFF.
- Assert Reset in HOLD → outputs return to defaults immediately, asynchronously, stall_count=0. After release, a new hazard is detected normally.
